// File: rtl/bu2_point.sv
// rtl/bu2_point.sv - 4-stage modular NTT butterfly B0=(A0+A1*Y) mod q, B1=(A0-A1*Y) mod q; optional BU2POINT_VALID_EN
module bu2_point #(
    parameter int BIT_SIZE = 60
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [BIT_SIZE-1:0] A0,
    input  logic [BIT_SIZE-1:0] A1,
    input  logic [BIT_SIZE-1:0] Y,
    input  logic [BIT_SIZE-1:0] q,
    output logic [BIT_SIZE-1:0] B0,
    output logic [BIT_SIZE-1:0] B1
`ifdef BU2POINT_VALID_EN
    ,
    input  logic                in_valid,
    output logic                out_valid
`endif
);

    localparam int PW = 2 * BIT_SIZE;

    // Per-stage load enables: tied high unless the valid pipe is built in
    logic en1, en2, en3, en4;

`ifdef BU2POINT_VALID_EN
    logic [3:0] vld;

    // Valid bit rides alongside the data, one position per stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld <= '0;
        end else begin
            vld <= {vld[2:0], in_valid};
        end
    end

    assign en1       = in_valid;
    assign en2       = vld[0];
    assign en3       = vld[1];
    assign en4       = vld[2];
    assign out_valid = vld[3];
`else
    assign en1 = 1'b1;
    assign en2 = 1'b1;
    assign en3 = 1'b1;
    assign en4 = 1'b1;
`endif

    // Stage 1: operand capture
    logic [BIT_SIZE-1:0] a0_1, a1_1, y_1, q_1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a0_1 <= '0;
            a1_1 <= '0;
            y_1  <= '0;
            q_1  <= '0;
        end else if (en1) begin
            a0_1 <= A0;
            a1_1 <= A1;
            y_1  <= Y;
            q_1  <= q;
        end
    end

    // Stage 2: full-width product, A0 and q delayed alongside
    logic [PW-1:0]       p_2;
    logic [BIT_SIZE-1:0] a0_2, q_2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_2  <= '0;
            a0_2 <= '0;
            q_2  <= '0;
        end else if (en2) begin
            p_2  <= PW'(a1_1) * PW'(y_1);
            a0_2 <= a0_1;
            q_2  <= q_1;
        end
    end

    // Stage 3 reduction: both operands brought into [0, q-1]; q = 0 yields 0
    logic [BIT_SIZE-1:0] t_next, a0r_next;

    // Combinational reduce of product and A0, guarded against a zero modulus
    always_comb begin
        t_next   = '0;
        a0r_next = '0;
        if (q_2 != '0) begin
            t_next   = BIT_SIZE'(p_2 % PW'(q_2));
            a0r_next = a0_2 % q_2;
        end
    end

    logic [BIT_SIZE-1:0] t_3, a0r_3, q_3;

    // Stage 3 register: reduced operands and delayed modulus
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t_3   <= '0;
            a0r_3 <= '0;
            q_3   <= '0;
        end else if (en3) begin
            t_3   <= t_next;
            a0r_3 <= a0r_next;
            q_3   <= q_2;
        end
    end

    // Stage 4 arithmetic: both inputs are already < q, so one conditional correction suffices
    logic [BIT_SIZE:0]   sum;
    logic [BIT_SIZE-1:0] b0_next, b1_next;

    // Modular add/subtract with single-step correction
    always_comb begin
        sum     = {1'b0, a0r_3} + {1'b0, t_3};
        b0_next = '0;
        b1_next = '0;
        if (q_3 != '0) begin
            if (sum >= {1'b0, q_3}) begin
                b0_next = BIT_SIZE'(sum - {1'b0, q_3});
            end else begin
                b0_next = sum[BIT_SIZE-1:0];
            end
            if (a0r_3 >= t_3) begin
                b1_next = a0r_3 - t_3;
            end else begin
                b1_next = a0r_3 - t_3 + q_3;
            end
        end
    end

    // Stage 4: registered results, held while the stage is not enabled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            B0 <= '0;
            B1 <= '0;
        end else if (en4) begin
            B0 <= b0_next;
            B1 <= b1_next;
        end
    end

endmodule

// File: tb/tb_bu2_point.sv
// tb/tb_bu2_point.sv - randomized self-checking bench for bu2_point against an arithmetic reference
module tb_bu2_point;

    localparam int W    = 60;
    localparam int NVEC = 100;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] A0, A1, Y, q;
    logic [W-1:0] B0, B1;
`ifdef BU2POINT_VALID_EN
    logic         in_valid = 1'b0;
    logic         out_valid;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] hold_b0 = '0;
    logic [W-1:0] hold_b1 = '0;

    typedef struct {
        logic [W-1:0] a0, a1, y, q;
        bit           v;
    } vec_t;

    vec_t vs[NVEC];

    bu2_point #(.BIT_SIZE(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .A0        (A0),
        .A1        (A1),
        .Y         (Y),
        .q         (q),
        .B0        (B0),
        .B1        (B1)
`ifdef BU2POINT_VALID_EN
        ,
        .in_valid  (in_valid),
        .out_valid (out_valid)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_b0(input logic [W-1:0] a0, a1, y, m);
        logic [127:0] s;
        if (m == '0) return '0;
        s = 128'(a0) + 128'(a1) * 128'(y);
        return W'(s % 128'(m));
    endfunction

    function automatic logic [W-1:0] ref_b1(input logic [W-1:0] a0, a1, y, m);
        logic [127:0] pr, ar;
        if (m == '0) return '0;
        pr = (128'(a1) * 128'(y)) % 128'(m);
        ar = 128'(a0) % 128'(m);
        return W'((ar + 128'(m) - pr) % 128'(m));
    endfunction

    task automatic drive(input logic [W-1:0] a0, a1, y, m, input bit v);
        A0 = a0;
        A1 = a1;
        Y  = y;
        q  = m;
`ifdef BU2POINT_VALID_EN
        in_valid = v;
`endif
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a0, a1, y, m,
                            input logic [W-1:0] e0, e1);
        @(negedge clk);
        drive(a0, a1, y, m, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check({tag, ".B0"}, 64'(B0), 64'(e0));
        check({tag, ".B1"}, 64'(B1), 64'(e1));
        hold_b0 = e0;
        hold_b1 = e1;
    endtask

    initial begin
        logic [W-1:0] qmax;
        qmax = W'(64'h0FFF_FFFF_FFFF_FFA3);

        // Reset held low with random inputs
        drive(rnd(), rnd(), rnd(), rnd(), 1'b1);
        repeat (3) @(negedge clk);
        check("reset.B0", 64'(B0), 64'd0);
        check("reset.B1", 64'(B1), 64'd0);
        rstn = 1'b1;

        directed("basic", 5000, 7000, 3000, 9000, 8000, 2000);

        // Asynchronous reset mid-stream, between clock edges
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async_rst.B0", 64'(B0), 64'd0);
        check("async_rst.B1", 64'(B1), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        drive(10, 10, 10, 17, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("flush.B0", 64'(B0), 64'd0);
        check("flush.B1", 64'(B1), 64'd0);
        @(posedge clk);
        #1;
        check("post_rst.B0", 64'(B0), 64'd8);
        check("post_rst.B1", 64'(B1), 64'd12);

        directed("wrap1", 10, 10, 10, 17, 8, 12);
        directed("wrap2", 0, 1, 1, 17, 1, 16);
        directed("maxw", qmax - 1, qmax - 1, qmax - 1, qmax, 0, qmax - 2);
        directed("a0_ge_q", 20, 0, 5, 7, 6, 6);
        directed("q0", rnd(), rnd(), rnd(), 0, 0, 0);
        directed("q1", rnd(), rnd(), rnd(), 1, 0, 0);

        // Random stream, one vector per cycle
        for (int i = 0; i < NVEC; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            vs[i].a0 = rnd();
            vs[i].a1 = (sel == 3) ? W'(0) : rnd();
            vs[i].y  = rnd();
            case (sel)
                0:       vs[i].q = '0;
                1:       vs[i].q = W'(1);
                2:       vs[i].q = W'($urandom_range(2, 100));
                default: vs[i].q = rnd();
            endcase
`ifdef BU2POINT_VALID_EN
            vs[i].v = ($urandom_range(0, 3) != 0);
`else
            vs[i].v = 1'b1;
`endif
        end

        for (int i = 0; i < NVEC + 4; i++) begin
            @(negedge clk);
            if (i >= 4) begin
                int k;
                k = i - 4;
                if (vs[k].v) begin
                    hold_b0 = ref_b0(vs[k].a0, vs[k].a1, vs[k].y, vs[k].q);
                    hold_b1 = ref_b1(vs[k].a0, vs[k].a1, vs[k].y, vs[k].q);
                end
`ifdef BU2POINT_VALID_EN
                check($sformatf("stream[%0d].out_valid", k), 64'(out_valid), 64'(vs[k].v));
`endif
                check($sformatf("stream[%0d].B0", k), 64'(B0), 64'(hold_b0));
                check($sformatf("stream[%0d].B1", k), 64'(B1), 64'(hold_b1));
            end
            if (i < NVEC) begin
                drive(vs[i].a0, vs[i].a1, vs[i].y, vs[i].q, vs[i].v);
            end else begin
                drive(rnd(), rnd(), rnd(), rnd(), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bu2_point.md
Name: bu2_point

Overview:
- Pipelined 2-point Cooley-Tukey NTT butterfly over the integers mod q.
- Computes B0 = (A0 + A1·Y) mod q and B1 = (A0 − A1·Y) mod q.
- Used as the core butterfly in the NTT datapath built on the 64-bit multiplier.
- Fully pipelined: accepts a new operand set every clock.

Parameters:
- BIT_SIZE, 60, width of operands, modulus and results.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  reset: one clock; reset is asynchronous and active-low.
- A0  input  BIT_SIZE  first butterfly operand.
- A1  input  BIT_SIZE  second operand, multiplied by the twiddle.
- Y  input  BIT_SIZE  twiddle factor.
- q  input  BIT_SIZE  modulus; sampled with the operands and carried down the pipeline with them.
- B0  output  BIT_SIZE  (A0 + A1·Y) mod q, registered.
- B1  output  BIT_SIZE  (A0 − A1·Y) mod q, registered.

Behaviour:
- rstn low clears every pipeline register asynchronously; B0 = B1 = 0 while in reset.
- Release of reset is synchronous to clk.
- S1: register A0, A1, Y, q.
- S2: P = A1·Y, full 2·BIT_SIZE-bit unsigned product, registered. A0 and q are delayed alongside.
- S3: T = P mod q and A0r = A0 mod q, both registered; q delayed.
- S4: registered outputs.
  - S = A0r + T, computed with 1 extra bit; B0 = S − q if S ≥ q, else S.
  - B1 = A0r − T if A0r ≥ T, else A0r − T + q.
- Latency: exactly 4 rising edges from input sampling to B0/B1 valid. Throughput: 1 per cycle.
- Operands with no validity qualifier are continuously processed; outputs always reflect the inputs present 4 edges earlier.
- All arithmetic is unsigned; there is no overflow beyond the stated widths. Results are always in [0, q−1] when q ≥ 1.
- q = 0: T, A0r, B0 and B1 are all forced to 0, with no division by zero. q = 1: outputs are 0.
- A0 ≥ q or A1/Y ≥ q is legal; the reductions above make the results correct.
- Reset asserted mid-stream flushes all in-flight data. The first valid result appears 4 edges after the first post-reset sampling edge.
- The S3 mod may be combinational or a fixed-depth restoring structure. The total latency must remain exactly 4.

Optional Feature:
- Macro BU2POINT_VALID_EN.
- When defined, adds an input in_valid (1 bit) and an output out_valid (1 bit).
  - in_valid is piped through a 4-deep shift register, reset to 0.
  - out_valid is high exactly 4 edges after in_valid was sampled high.
  - Data registers load only when their stage's valid bit is set; otherwise they hold their value.
  - B0/B1 keep their last valid result while out_valid = 0.
- When not defined, there are no extra ports and every stage loads every cycle.

Test Plan:
- Reset: hold rstn = 0 with random inputs. B0 = B1 = 0. Assert rstn low asynchronously mid-stream; outputs go to 0 immediately, without waiting for a clock edge.
- Basic: A0 = 5000, A1 = 7000, Y = 3000, q = 9000, held stable. After 4 edges, B0 = 8000 and B1 = 2000.
- Wrap: A0 = 10, A1 = 10, Y = 10, q = 17 gives B0 = 8 and B1 = 12. A0 = 0, A1 = 1, Y = 1, q = 17 gives B0 = 1 and B1 = 16.
- Max width: q = 2^60 − 93, A0 = A1 = Y = q − 1 gives B0 = 0 and B1 = q − 2. A0 = 20, A1 = 0, Y = 5, q = 7 (A0 ≥ q) gives B0 = B1 = 6.
- Degenerate modulus: q = 0 with any operands gives B0 = B1 = 0. q = 1 gives 0, 0.
- Streaming: apply 100 random vectors back-to-back, one per cycle. Each output pair matches a reference model of the vector applied 4 cycles earlier. With BU2POINT_VALID_EN defined, out_valid mirrors in_valid delayed by 4, including for gapped patterns.
